tap_ctrl_param: RTL and testbench

Parametrised IEEE 1149.1-style TAP controller: the successor to the fixed 16-state TAP route block, which only observed state. It adds an instruction register, a BYPASS register, optional IDCODE and NUM_DR user data registers with capture/update handshakes to the core. All logic runs on the global clock GCLK_Pad, and the 4-bit state code stays observable on state_obs_Pad for wafer-level debug.

---
 rtl/tap_pkg.sv | 33 +++
 rtl/tap_ctrl_param_fsm.sv | 41 ++++
 rtl/tap_ctrl_param.sv | 137 +++++++++++++
 tb/tb_tap_ctrl_param.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encoding, opcode helpers and the IR capture pattern.
package tap_pkg;

    typedef enum logic [3:0] {
        ST_EX2_DR = 4'h0,
        ST_EX1_DR = 4'h1,
        ST_SH_DR  = 4'h2,
        ST_PAU_DR = 4'h3,
        ST_SEL_IR = 4'h4,
        ST_UPD_DR = 4'h5,
        ST_CAP_DR = 4'h6,
        ST_SEL_DR = 4'h7,
        ST_EX2_IR = 4'h8,
        ST_EX1_IR = 4'h9,
        ST_SH_IR  = 4'hA,
        ST_PAU_IR = 4'hB,
        ST_RTI    = 4'hC,
        ST_UPD_IR = 4'hD,
        ST_CAP_IR = 4'hE,
        ST_TLR    = 4'hF
    } tap_state_t;

    localparam logic [1:0] IR_CAPTURE = 2'b01;

    function automatic logic [31:0] bypass_op(input int unsigned ir_width);
        return (ir_width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << ir_width) - 32'd1);
    endfunction

    function automatic logic [31:0] idcode_op(input int unsigned ir_width);
        return bypass_op(ir_width) - 32'd1;
    endfunction

endpackage

// File: rtl/tap_ctrl_param_fsm.sv
// TAP state register and TMS-driven next-state graph; TRST_Pad forces Test-Logic-Reset.
module tap_fsm
    import tap_pkg::*;
(
    input  logic       GCLK_Pad,
    input  logic       TRST_Pad,
    input  logic       TMS_Pad,
    output logic [3:0] state_o
);

    tap_state_t state_q;

    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad) begin
            state_q <= ST_TLR;
        end else begin
            case (state_q)
                ST_TLR:    state_q <= TMS_Pad ? ST_TLR    : ST_RTI;
                ST_RTI:    state_q <= TMS_Pad ? ST_SEL_DR : ST_RTI;
                ST_SEL_DR: state_q <= TMS_Pad ? ST_SEL_IR : ST_CAP_DR;
                ST_CAP_DR: state_q <= TMS_Pad ? ST_EX1_DR : ST_SH_DR;
                ST_SH_DR:  state_q <= TMS_Pad ? ST_EX1_DR : ST_SH_DR;
                ST_EX1_DR: state_q <= TMS_Pad ? ST_UPD_DR : ST_PAU_DR;
                ST_PAU_DR: state_q <= TMS_Pad ? ST_EX2_DR : ST_PAU_DR;
                ST_EX2_DR: state_q <= TMS_Pad ? ST_UPD_DR : ST_SH_DR;
                ST_UPD_DR: state_q <= TMS_Pad ? ST_SEL_DR : ST_RTI;
                ST_SEL_IR: state_q <= TMS_Pad ? ST_TLR    : ST_CAP_IR;
                ST_CAP_IR: state_q <= TMS_Pad ? ST_EX1_IR : ST_SH_IR;
                ST_SH_IR:  state_q <= TMS_Pad ? ST_EX1_IR : ST_SH_IR;
                ST_EX1_IR: state_q <= TMS_Pad ? ST_UPD_IR : ST_PAU_IR;
                ST_PAU_IR: state_q <= TMS_Pad ? ST_EX2_IR : ST_PAU_IR;
                ST_EX2_IR: state_q <= TMS_Pad ? ST_UPD_IR : ST_SH_IR;
                ST_UPD_IR: state_q <= TMS_Pad ? ST_SEL_DR : ST_RTI;
                default:   state_q <= ST_TLR;
            endcase
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/tap_ctrl_param.sv
// Parametrised TAP controller: IR, BYPASS, user DRs with update strobes, optional IDCODE.
// Define TAP_IDCODE_EN to build the 32-bit IDCODE register and make it the reset instruction.
module tap_ctrl_param
    import tap_pkg::*;
#(
    parameter int          IR_WIDTH     = 4,
    parameter int          DR_WIDTH     = 8,
    parameter int          NUM_DR       = 2,
    parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
    input  logic                       GCLK_Pad,
    input  logic                       TRST_Pad,
    input  logic                       TMS_Pad,
    input  logic                       TDI_Pad,
    output logic                       TDO_Pad,
    output logic [3:0]                 state_obs_Pad,
    output logic [IR_WIDTH-1:0]        ir_out,
    input  logic [NUM_DR*DR_WIDTH-1:0] dr_capture_data,
    output logic [DR_WIDTH-1:0]        dr_update_data,
    output logic [NUM_DR-1:0]          dr_update_strb
);

    localparam logic [31:0]         BYP_OP32 = bypass_op(IR_WIDTH);
    localparam logic [31:0]         IDC_OP32 = idcode_op(IR_WIDTH);
    localparam logic [IR_WIDTH-1:0] BYP_OP   = BYP_OP32[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IDC_OP   = IDC_OP32[IR_WIDTH-1:0];
    localparam logic [IR_WIDTH-1:0] IR_CAP   = IR_WIDTH'(IR_CAPTURE);
    localparam logic [IR_WIDTH-1:0] NUM_DR_L = IR_WIDTH'(NUM_DR);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] RESET_IR = IDC_OP;
`else
    localparam logic [IR_WIDTH-1:0] RESET_IR = BYP_OP;
`endif

    if (IDCODE_VALUE[0] != 1'b1 || IR_WIDTH < 2) begin : g_param_check
        $error("tap_ctrl_param: IDCODE_VALUE[0] must be 1 and IR_WIDTH at least 2");
    end

    logic [3:0]          fsm_state;
    tap_state_t          state;
    logic [IR_WIDTH-1:0] ir_q;
    logic [IR_WIDTH-1:0] ir_shift_q;
    logic [DR_WIDTH-1:0] user_shift_q;
    logic                bypass_q;
    logic                sel_user;
    logic                sel_bypass;
    logic [DR_WIDTH-1:0] user_cap;
    logic [DR_WIDTH-1:0] cap_arr [NUM_DR];
    logic                tdo;
`ifdef TAP_IDCODE_EN
    logic [31:0]         idcode_q;
    logic                sel_idcode;
`endif

    tap_fsm u_fsm (
        .GCLK_Pad (GCLK_Pad),
        .TRST_Pad (TRST_Pad),
        .TMS_Pad  (TMS_Pad),
        .state_o  (fsm_state)
    );

    assign state         = tap_state_t'(fsm_state);
    assign state_obs_Pad = fsm_state;
    assign ir_out        = (state == ST_TLR) ? RESET_IR : ir_q;

    // Decode always works from the active instruction, so TLR sees the reset opcode at once.
    assign sel_user = (ir_out < NUM_DR_L);
`ifdef TAP_IDCODE_EN
    assign sel_idcode = (ir_out == IDC_OP);
    assign sel_bypass = !sel_user && !sel_idcode;
`else
    assign sel_bypass = !sel_user;
`endif

    for (genvar gi = 0; gi < NUM_DR; gi++) begin : g_user_dr
        assign cap_arr[gi]        = dr_capture_data[gi*DR_WIDTH +: DR_WIDTH];
        assign dr_update_strb[gi] = (state == ST_UPD_DR) && sel_user && (ir_out == IR_WIDTH'(gi));
    end

    always_comb begin
        user_cap = '0;
        for (int k = 0; k < NUM_DR; k++) begin
            if (ir_out == IR_WIDTH'(k)) user_cap = cap_arr[k];
        end
    end

    always_ff @(posedge GCLK_Pad) begin
        if (TRST_Pad) begin
            ir_q         <= RESET_IR;
            ir_shift_q   <= '0;
            user_shift_q <= '0;
            bypass_q     <= 1'b0;
`ifdef TAP_IDCODE_EN
            idcode_q     <= '0;
`endif
        end else begin
            case (state)
                ST_TLR:    ir_q       <= RESET_IR;
                ST_CAP_IR: ir_shift_q <= IR_CAP;
                ST_SH_IR:  ir_shift_q <= {TDI_Pad, ir_shift_q[IR_WIDTH-1:1]};
                ST_UPD_IR: ir_q       <= ir_shift_q;
                ST_CAP_DR: begin
                    if (sel_user)   user_shift_q <= user_cap;
                    if (sel_bypass) bypass_q     <= 1'b0;
`ifdef TAP_IDCODE_EN
                    if (sel_idcode) idcode_q     <= IDCODE_VALUE;
`endif
                end
                ST_SH_DR: begin
                    if (sel_user)   user_shift_q <= {TDI_Pad, user_shift_q[DR_WIDTH-1:1]};
                    if (sel_bypass) bypass_q     <= TDI_Pad;
`ifdef TAP_IDCODE_EN
                    if (sel_idcode) idcode_q     <= {TDI_Pad, idcode_q[31:1]};
`endif
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tdo = 1'b0;
        if (state == ST_SH_IR) begin
            tdo = ir_shift_q[0];
        end else if (state == ST_SH_DR) begin
            if (sel_user)   tdo = user_shift_q[0];
`ifdef TAP_IDCODE_EN
            else if (sel_idcode) tdo = idcode_q[0];
`endif
            else            tdo = bypass_q;
        end
    end

    assign TDO_Pad        = tdo;
    assign dr_update_data = user_shift_q;

endmodule

// File: tb/tb_tap_ctrl_param.sv
// Self-checking bench for tap_ctrl_param: directed scans plus a randomized walk against a TAP model.
module tb_tap_ctrl_param;

    localparam int          IRW = 4;
    localparam int          DRW = 8;
    localparam int          NDR = 2;
    localparam logic [31:0] IDV = 32'h4BA0_0477;
`ifdef TAP_IDCODE_EN
    localparam logic [3:0]  RST_IR = 4'hE;
    localparam bit          IDC_EN = 1'b1;
`else
    localparam logic [3:0]  RST_IR = 4'hF;
    localparam bit          IDC_EN = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 trst = 1'b1;
    logic                 tms = 1'b1;
    logic                 tdi = 1'b0;
    logic                 tdo;
    logic [3:0]           state_obs;
    logic [IRW-1:0]       ir_out;
    logic [NDR*DRW-1:0]   dr_cap = '0;
    logic [DRW-1:0]       upd_data;
    logic [NDR-1:0]       upd_strb;

    int checks = 0;
    int errors = 0;

    // Standard TMS graph, indexed by state code: next state for TMS=0 and TMS=1.
    int nxt0 [16] = '{2, 3, 2, 3, 14, 12, 2, 6, 10, 11, 10, 11, 12, 12, 10, 12};
    int nxt1 [16] = '{5, 5, 1, 0, 15, 7, 1, 4, 13, 13, 9, 8, 7, 7, 9, 15};

    int unsigned m_state, m_ir, m_irsh, m_user, m_byp, m_id;

    tap_ctrl_param #(
        .IR_WIDTH     (IRW),
        .DR_WIDTH     (DRW),
        .NUM_DR       (NDR),
        .IDCODE_VALUE (IDV)
    ) dut (
        .GCLK_Pad        (clk),
        .TRST_Pad        (trst),
        .TMS_Pad         (tms),
        .TDI_Pad         (tdi),
        .TDO_Pad         (tdo),
        .state_obs_Pad   (state_obs),
        .ir_out          (ir_out),
        .dr_capture_data (dr_cap),
        .dr_update_data  (upd_data),
        .dr_update_strb  (upd_strb)
    );

    always #5 clk = ~clk;

    task automatic drive(input bit tms_v, input bit tdi_v);
        @(negedge clk);
        tms = tms_v;
        tdi = tdi_v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        trst = 1'b1;
        drive(1'b0, 1'b1);
        trst = 1'b0;
        checks++; if (state_obs !== 4'hF) begin errors++; $display("FAIL reset_state got %h exp F", state_obs); end
        checks++; if (upd_strb !== 2'b00) begin errors++; $display("FAIL reset_strb got %b exp 00", upd_strb); end
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b exp 0", tdo); end
        checks++; if (ir_out !== RST_IR) begin errors++; $display("FAIL reset_ir got %h exp %h", ir_out, RST_IR); end
        drive(1'b0, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
        checks++; if (state_obs !== 4'h2) begin errors++; $display("FAIL escape_enter got %h exp 2", state_obs); end
        repeat (5) drive(1'b1, 1'b0);
        checks++; if (state_obs !== 4'hF) begin errors++; $display("FAIL tlr_escape got %h exp F", state_obs); end
        $display("reset: state=%h ir_out=%h", state_obs, ir_out);
    endtask

    task automatic test_fsm_walk;
        bit         tms_seq [9];
        logic [3:0] exp_seq [9];
        tms_seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_seq = '{4'hC, 4'h7, 4'h6, 4'h2, 4'h1, 4'h5, 4'h7, 4'h4, 4'hE};
        for (int i = 0; i < 9; i++) begin
            drive(tms_seq[i], 1'b0);
            checks++;
            if (state_obs !== exp_seq[i]) begin
                errors++; $display("FAIL walk_%0d got %h exp %h", i, state_obs, exp_seq[i]);
            end
            checks++;
            if (upd_strb !== 2'b00) begin errors++; $display("FAIL walk_strb_%0d got %b exp 00", i, upd_strb); end
        end
        repeat (5) drive(1'b1, 1'b0);
        $display("fsm_walk: end state=%h", state_obs);
    endtask

    // Entered from TLR or RTI, leaves the TAP in RTI with the new instruction active.
    task automatic test_ir_scan(input logic [3:0] code);
        logic [3:0] cap_pat;
        cap_pat = 4'b0001;
        drive(1'b0, 1'b0); drive(1'b1, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
        for (int i = 0; i < IRW; i++) begin
            checks++;
            if (tdo !== cap_pat[i]) begin errors++; $display("FAIL ir_tdo_%0d got %b exp %b", i, tdo, cap_pat[i]); end
            drive(i == IRW - 1, code[i]);
        end
        drive(1'b1, 1'b0);
        checks++; if (state_obs !== 4'hD) begin errors++; $display("FAIL ir_updir got %h exp D", state_obs); end
        drive(1'b0, 1'b0);
        checks++; if (ir_out !== code) begin errors++; $display("FAIL ir_load got %h exp %h", ir_out, code); end
        $display("ir_scan: code=%h ir_out=%h", code, ir_out);
    endtask

    task automatic test_user_dr(input int k, input logic [7:0] cap, input logic [7:0] shin);
        dr_cap = NDR*DRW'($urandom);
        dr_cap[k*DRW +: DRW] = cap;
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
        dr_cap = NDR*DRW'($urandom);
        for (int i = 0; i < DRW; i++) begin
            checks++;
            if (tdo !== cap[i]) begin errors++; $display("FAIL dr%0d_tdo_%0d got %b exp %b", k, i, tdo, cap[i]); end
            drive(i == DRW - 1, shin[i]);
        end
        checks++; if (upd_strb !== 2'b00) begin errors++; $display("FAIL dr%0d_strb_ex1 got %b exp 00", k, upd_strb); end
        drive(1'b1, 1'b0);
        checks++;
        if (upd_strb !== 2'(1 << k)) begin errors++; $display("FAIL dr%0d_strb got %b exp %b", k, upd_strb, 2'(1 << k)); end
        checks++;
        if (upd_data !== shin) begin errors++; $display("FAIL dr%0d_data got %h exp %h", k, upd_data, shin); end
        drive(1'b0, 1'b0);
        checks++; if (upd_strb !== 2'b00) begin errors++; $display("FAIL dr%0d_strb_after got %b exp 00", k, upd_strb); end
        $display("user_dr%0d: cap=%h shifted_in=%h update=%h", k, cap, shin, upd_data);
    endtask

    // Expects the TAP in RTI with a BYPASS-decoding instruction active.
    task automatic test_bypass(input string nm);
        bit seq [4];
        bit prev;
        seq  = '{1'b1, 1'b0, 1'b1, 1'b1};
        prev = 1'b0;
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (tdo !== prev) begin errors++; $display("FAIL %s_tdo_%0d got %b exp %b", nm, i, tdo, prev); end
            drive(i == 3, seq[i]);
            prev = seq[i];
        end
        drive(1'b1, 1'b0);
        checks++; if (upd_strb !== 2'b00) begin errors++; $display("FAIL %s_strb got %b exp 00", nm, upd_strb); end
        drive(1'b0, 1'b0);
        $display("%s: ir_out=%h scan complete", nm, ir_out);
    endtask

    task automatic test_idcode;
        trst = 1'b1;
        drive(1'b1, 1'b0);
        trst = 1'b0;
`ifdef TAP_IDCODE_EN
        drive(1'b0, 1'b0); drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
        for (int i = 0; i < 32; i++) begin
            checks++;
            if (tdo !== IDV[i]) begin errors++; $display("FAIL idcode_bit_%0d got %b exp %b", i, tdo, IDV[i]); end
            drive(1'b0, 1'($urandom));
        end
        $display("idcode: %h shifted out", IDV);
`else
        test_ir_scan(4'hE);
        test_bypass("idcode_as_bypass");
        drive(1'b1, 1'b0); drive(1'b0, 1'b0); drive(1'b0, 1'b0);
`endif
        repeat (5) drive(1'b0, 1'b1);
        trst = 1'b1;
        drive(1'b0, 1'b0);
        trst = 1'b0;
        checks++; if (state_obs !== 4'hF) begin errors++; $display("FAIL midscan_state got %h exp F", state_obs); end
        checks++; if (upd_strb !== 2'b00) begin errors++; $display("FAIL midscan_strb got %b exp 00", upd_strb); end
        checks++; if (tdo !== 1'b0) begin errors++; $display("FAIL midscan_tdo got %b exp 0", tdo); end
        checks++; if (ir_out !== RST_IR) begin errors++; $display("FAIL midscan_ir got %h exp %h", ir_out, RST_IR); end
    endtask

    // Reference TAP advanced once per clock edge with the inputs seen at that edge.
    task automatic model_step(input bit tms_v, input bit tdi_v, input bit trst_v, input logic [15:0] cap_v);
        int unsigned air;
        bit su, sid;
        if (trst_v) begin
            m_state = 15; m_ir = RST_IR; m_irsh = 0; m_user = 0; m_byp = 0; m_id = 0;
            return;
        end
        air = (m_state == 15) ? RST_IR : m_ir;
        su  = air < NDR;
        sid = IDC_EN && air == 14;
        case (m_state)
            15: m_ir = RST_IR;
            14: m_irsh = 1;
            10: m_irsh = (m_irsh >> 1) | (int'(tdi_v) << 3);
            13: m_ir = m_irsh;
            6: begin
                if (su)       m_user = (int'(cap_v) >> (8 * air)) & 32'hFF;
                else if (sid) m_id = IDV;
                else          m_byp = 0;
            end
            2: begin
                if (su)       m_user = (m_user >> 1) | (int'(tdi_v) << 7);
                else if (sid) m_id = (m_id >> 1) | (int'(tdi_v) << 31);
                else          m_byp = tdi_v;
            end
            default: ;
        endcase
        m_state = tms_v ? nxt1[m_state] : nxt0[m_state];
    endtask

    task automatic test_random(input int cycles);
        int unsigned air, e_tdo, e_strb;
        bit su, sid, r_tms, r_tdi, r_trst;
        logic [15:0] r_cap;
        trst = 1'b1;
        model_step(1'b0, 1'b0, 1'b1, dr_cap);
        drive(1'b0, 1'b0);
        trst = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            air    = (m_state == 15) ? RST_IR : m_ir;
            su     = air < NDR;
            sid    = IDC_EN && air == 14;
            e_tdo  = 0;
            if (m_state == 10) e_tdo = m_irsh & 1;
            else if (m_state == 2) e_tdo = su ? (m_user & 1) : (sid ? (m_id & 1) : m_byp);
            e_strb = (m_state == 5 && su) ? (1 << air) : 0;
            checks++; if (state_obs !== 4'(m_state)) begin errors++; $display("FAIL rnd_state_%0d got %h exp %h", n, state_obs, 4'(m_state)); end
            checks++; if (ir_out !== 4'(air)) begin errors++; $display("FAIL rnd_ir_%0d got %h exp %h", n, ir_out, 4'(air)); end
            checks++; if (tdo !== 1'(e_tdo)) begin errors++; $display("FAIL rnd_tdo_%0d got %b exp %b", n, tdo, 1'(e_tdo)); end
            checks++; if (upd_strb !== 2'(e_strb)) begin errors++; $display("FAIL rnd_strb_%0d got %b exp %b", n, upd_strb, 2'(e_strb)); end
            checks++; if (upd_data !== 8'(m_user)) begin errors++; $display("FAIL rnd_data_%0d got %h exp %h", n, upd_data, 8'(m_user)); end
            r_tms  = ($urandom_range(0, 99) < 30);
            r_tdi  = 1'($urandom);
            r_trst = ($urandom_range(0, 199) == 0);
            r_cap  = 16'($urandom);
            trst   = r_trst;
            dr_cap = r_cap;
            model_step(r_tms, r_tdi, r_trst, r_cap);
            drive(r_tms, r_tdi);
        end
        trst = 1'b0;
        $display("random: %0d cycles compared against model", cycles);
    endtask

    initial begin
        test_reset();
        test_fsm_walk();
        test_ir_scan(4'h1);
        test_user_dr(1, 8'hA5, 8'h3C);
        test_ir_scan(4'h0);
        test_user_dr(0, 8'($urandom), 8'($urandom));
        test_ir_scan(4'hF);
        test_bypass("bypass");
        test_ir_scan(4'h7);
        test_bypass("bypass_unused_code");
        test_idcode();
        test_random(1500);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
